// File: rtl/axis_pattern_gen_v2.sv
// AXI4-Stream video test-pattern source.
// Emits H_RES x V_RES frames of RGB565 (DATA_WIDTH=16) or RGB888 (DATA_WIDTH=24) pixels with
// start-of-frame on tuser[0] and end-of-line on tlast. Full tready backpressure, eight patterns
// (two animated), optional FRAME_GAP idle cycles after each frame.
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   mode_i               : pattern select, latched at each frame start
//   enable_i             : run request; a started frame always completes
//   m_axis_t*            : AXI4-Stream master (tdata/tvalid/tready/tlast/tuser)
//   frame_cnt_o          : completed frame count, wraps
//   busy_o               : high while a frame or the inter-frame gap is in progress
module axis_pattern_gen_v2 #(
  parameter int unsigned H_RES      = 800,
  parameter int unsigned V_RES      = 600,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned FRAME_GAP  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2:0]            mode_i,
  input  logic                  enable_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [15:0]           frame_cnt_o,
  output logic                  busy_o
);

  if (!(DATA_WIDTH == 16 || DATA_WIDTH == 24)) begin : g_bad_width
    $error("axis_pattern_gen_v2: DATA_WIDTH must be 16 or 24");
  end

  localparam int unsigned XW = $clog2(H_RES);
  localparam int unsigned YW = $clog2(V_RES);
  localparam logic [XW-1:0] XMax = XW'(H_RES - 1);
  localparam logic [YW-1:0] YMax = YW'(V_RES - 1);
  localparam logic [15:0] GapLast = 16'(FRAME_GAP - 1);

  // Left edge of each colour bar.
  localparam int unsigned BarEdge [8] = '{0, H_RES / 8, 2 * H_RES / 8, 3 * H_RES / 8,
                                          4 * H_RES / 8, 5 * H_RES / 8, 6 * H_RES / 8,
                                          7 * H_RES / 8};

  typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [2:0]      mode_q, mode_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [XW-1:0]   pos_q, pos_d;   // frame_cnt mod H_RES
  logic [1:0]      col_q, col_d;   // frame_cnt mod 3
  logic [15:0]     gap_q, gap_d;
  logic            busy_q, busy_d;
  logic            tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic            tlast_q, tlast_d;
  logic            tuser_q, tuser_d;

  // load_px: register the pixel at (x_d, y_d); clear_px: drop tvalid and zero the beat.
  logic            load_px, clear_px;

  // Control path.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    pos_d       = pos_q;
    col_d       = col_q;
    gap_d       = gap_q;
    load_px     = 1'b0;
    clear_px    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          mode_d  = mode_i;
          x_d     = '0;
          y_d     = '0;
          state_d = StActive;
          load_px = 1'b1;
        end
      end
      StActive: begin
        // tvalid is always high here, so tready alone marks a transfer.
        if (m_axis_tready) begin
          load_px = 1'b1;
          if (x_q == XMax) begin
            x_d = '0;
            if (y_q == YMax) begin
              y_d         = '0;
              frame_cnt_d = frame_cnt_q + 16'd1;
              pos_d       = (pos_q == XMax) ? '0 : pos_q + XW'(1);
              col_d       = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
              if (FRAME_GAP > 0) begin
                state_d  = StGap;
                gap_d    = '0;
                load_px  = 1'b0;
                clear_px = 1'b1;
              end else if (enable_i) begin
                mode_d = mode_i;
              end else begin
                state_d  = StIdle;
                load_px  = 1'b0;
                clear_px = 1'b1;
              end
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          gap_d = '0;
          if (enable_i) begin
            mode_d  = mode_i;
            state_d = StActive;
            load_px = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // Pixel generator: combinational from the next coordinates into the output register.
  logic [31:0]           xe;
  logic [7:0]            x8, y8, r8, g8, b8, v8;
  logic [2:0]            bar, rgb;
  logic [DATA_WIDTH-1:0] pix;

  always_comb begin
    xe  = 32'(x_d);
    x8  = xe[7:0];
    y8  = 8'(y_d);
    v8  = x8 ^ y8;
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (xe >= BarEdge[k]) bar = 3'(k);
    end
    unique case (bar)
      3'd0: rgb = 3'b111;  // white
      3'd1: rgb = 3'b110;  // yellow
      3'd2: rgb = 3'b011;  // cyan
      3'd3: rgb = 3'b010;  // green
      3'd4: rgb = 3'b101;  // magenta
      3'd5: rgb = 3'b100;  // red
      3'd6: rgb = 3'b001;  // blue
      default: rgb = 3'b000;
    endcase

    r8 = '0;
    g8 = '0;
    b8 = '0;
    unique case (mode_d)
      3'd0: r8 = '0;
      3'd1: begin r8 = '1; g8 = '1; b8 = '1; end
      3'd2: begin r8 = {8{rgb[2]}}; g8 = {8{rgb[1]}}; b8 = {8{rgb[0]}}; end
      3'd3: begin r8 = x8; g8 = x8; b8 = x8; end
      3'd4: if (!(x8[5] ^ y8[5])) begin r8 = '1; g8 = '1; b8 = '1; end
      3'd5: if (xe == 32'(pos_d)) begin r8 = '1; g8 = '1; b8 = '1; end
      3'd6: begin
        unique case (col_d)
          2'd0:    r8 = '1;
          2'd1:    g8 = '1;
          default: b8 = '1;
        endcase
      end
      default: begin r8 = v8; g8 = v8; b8 = v8; end
    endcase

    // Channels are MSB-aligned 8-bit values; RGB565 keeps the top 5/6/5 bits.
    if (DATA_WIDTH == 16) begin
      pix = DATA_WIDTH'(((32'(r8) >> 3) << 11) | ((32'(g8) >> 2) << 5) | (32'(b8) >> 3));
    end else begin
      pix = DATA_WIDTH'({r8, g8, b8});
    end

    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    if (load_px) begin
      tvalid_d = 1'b1;
      tdata_d  = pix;
      tlast_d  = (x_d == XMax);
      tuser_d  = (x_d == '0) && (y_d == '0);
    end else if (clear_px) begin
      tvalid_d = 1'b0;
      tdata_d  = '0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= '0;
      frame_cnt_q <= '0;
      pos_q       <= '0;
      col_q       <= '0;
      gap_q       <= '0;
      busy_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      pos_q       <= pos_d;
      col_q       <= col_d;
      gap_q       <= gap_d;
      busy_q      <= busy_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = USER_WIDTH'(tuser_q);
  assign frame_cnt_o   = frame_cnt_q;
  assign busy_o        = busy_q;

endmodule
